// File: rtl/bb_pkg.sv
// Shared brick-breaker definitions: game states, playfield and brick geometry,
// and the collision FSM state type.
package bb_pkg;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int PADDLE_Y   = 110;
    localparam int PADDLE_W   = 16;
    localparam int BRICK_Y0   = 16;
    localparam int BRICK_W    = 16;
    localparam int BRICK_H    = 8;
    localparam int BRICK_ROWS = 4;
    localparam int BRICK_COLS = 10;
    localparam int BRICK_N    = BRICK_ROWS * BRICK_COLS;

    localparam logic [2:0] ST_MAIN_MENU  = 3'd0;
    localparam logic [2:0] ST_LEVEL1     = 3'd1;
    localparam logic [2:0] ST_END_SCREEN = 3'd2;

    typedef enum logic [2:0] {
        C_IDLE,
        C_WALLS,
        C_LOOKUP,
        C_RESOLVE,
        C_REPORT
    } coll_state_t;

    function automatic logic [5:0] cell_index(input logic [1:0] row,
                                              input logic [3:0] col);
        return {1'b0, row, 3'b000} + {3'b000, row, 1'b0} + {2'b00, col};
    endfunction

endpackage

// File: rtl/brick_map.sv
// 40-cell brick store (row-major, 10 cells per row) with a live-brick counter.
// Reload wins over clear; cells outside the 4x10 field read as empty.
module brick_map
    import bb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] row,
    input  logic [3:0] col,
    input  logic       clear,
    input  logic       reload,
    output logic       hit,
    output logic [5:0] bricksLeft
);

    logic [BRICK_N-1:0] cells;
    logic [5:0]         idx;
    logic               inRange;

    assign idx     = cell_index(row, col);
    assign inRange = (col < 4'(BRICK_COLS));
    assign hit     = inRange && cells[idx];

    always_ff @(posedge clock) begin
        if (reset || reload) begin
            cells      <= '1;
            bricksLeft <= 6'(BRICK_N);
        end else if (clear && hit) begin
            cells[idx] <= 1'b0;
            bricksLeft <= bricksLeft - 6'd1;
        end
    end

endmodule

// File: rtl/collision_unit.sv
// Brick-breaker collision detector: walls, paddle and brick map, 4-cycle latency.
// Optional COLLIDE_SCORE_EN adds a saturating row-weighted score output.
module collision_unit
    import bb_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic        check,
    input  logic [7:0]  ballX,
    input  logic [7:0]  ballY,
    input  logic [7:0]  paddleX,
    output logic        cX,
    output logic        cY,
    output logic        cBrickX,
    output logic        cBrickY,
    output logic        ballLost,
    output logic        levelClear,
    output logic [5:0]  bricksLeft
`ifdef COLLIDE_SCORE_EN
    ,
    output logic [15:0] score
`endif
);

    coll_state_t cs, ns;

    logic [7:0] bx, by, px;
    logic       pX, pY, pLost, pBX, pBY;
    logic [1:0] rowq;
    logic [3:0] colq;
    logic       inField;
    logic       prevValid;
    logic [1:0] prevRow;
    logic [3:0] prevCol;

    logic       inLevel;
    logic       fieldY, fieldX;
    logic [1:0] rowc;
    logic [8:0] padHi;
    logic       padHit;
    logic       mapHit;
    logic       brickClr;
    logic       sameRow;
    logic       rep;

    assign inLevel = (state == ST_LEVEL1);

    always_ff @(posedge clock) begin
        if (reset) cs <= C_IDLE;
        else       cs <= ns;
    end

    always_comb begin
        ns = cs;
        unique case (cs)
            C_IDLE:    if (check && inLevel) ns = C_WALLS;
            C_WALLS:   ns = C_LOOKUP;
            C_LOOKUP:  ns = C_RESOLVE;
            C_RESOLVE: ns = C_REPORT;
            C_REPORT:  ns = C_IDLE;
            default:   ns = C_IDLE;
        endcase
        if (!inLevel) ns = C_IDLE;
    end

    assign fieldY = (by >= 8'(BRICK_Y0)) &&
                    (by <  8'(BRICK_Y0 + BRICK_ROWS * BRICK_H));
    assign fieldX = (bx <  8'(SCREEN_W));

    always_comb begin
        rowc = 2'd0;
        if (by >= 8'(BRICK_Y0 + 3 * BRICK_H))      rowc = 2'd3;
        else if (by >= 8'(BRICK_Y0 + 2 * BRICK_H)) rowc = 2'd2;
        else if (by >= 8'(BRICK_Y0 + BRICK_H))     rowc = 2'd1;
    end

    // 9-bit right edge so a paddle near the right wall does not wrap
    assign padHi  = {1'b0, px} + 9'(PADDLE_W - 1);
    assign padHit = (by == 8'(PADDLE_Y - 1)) && (bx >= px) &&
                    ({1'b0, bx} <= padHi);

    brick_map u_map (
        .clock      (clock),
        .reset      (reset),
        .row        (rowq),
        .col        (colq),
        .clear      (brickClr),
        .reload     (state == ST_MAIN_MENU),
        .hit        (mapHit),
        .bricksLeft (bricksLeft)
    );

    assign brickClr = (cs == C_RESOLVE) && inLevel && inField && mapHit;
    assign sameRow  = prevValid && (prevRow == rowq) && (prevCol != colq);

    always_ff @(posedge clock) begin
        if (reset) begin
            bx         <= '0;
            by         <= '0;
            px         <= '0;
            pX         <= 1'b0;
            pY         <= 1'b0;
            pLost      <= 1'b0;
            pBX        <= 1'b0;
            pBY        <= 1'b0;
            rowq       <= '0;
            colq       <= '0;
            inField    <= 1'b0;
            prevValid  <= 1'b0;
            prevRow    <= '0;
            prevCol    <= '0;
            levelClear <= 1'b0;
        end else begin
            if (cs == C_IDLE && check && inLevel) begin
                bx <= ballX;
                by <= ballY;
                px <= paddleX;
            end
            if (cs == C_WALLS) begin
                pX    <= (bx == 8'd0) || (bx >= 8'(SCREEN_W - 1));
                pY    <= (by == 8'd0);
                pLost <= (by >= 8'(SCREEN_H - 1));
            end
            if (cs == C_LOOKUP) begin
                if (padHit) pY <= 1'b1;
                rowq    <= rowc;
                colq    <= bx[7:4];
                inField <= fieldX && fieldY;
            end
            if (brickClr) begin
                if (sameRow) pBX <= 1'b1;
                else         pBY <= 1'b1;
            end
            // previous cell tracks every check; out-of-field checks invalidate it
            if (cs == C_RESOLVE && inLevel) begin
                prevValid <= inField;
                prevRow   <= rowq;
                prevCol   <= colq;
            end
            if (ns == C_IDLE) begin
                pX    <= 1'b0;
                pY    <= 1'b0;
                pLost <= 1'b0;
                pBX   <= 1'b0;
                pBY   <= 1'b0;
            end
            levelClear <= inLevel &&
                          ((bricksLeft == 6'd0) ||
                           (brickClr && bricksLeft == 6'd1));
        end
    end

    assign rep      = (cs == C_REPORT) && inLevel;
    assign cX       = rep && pX;
    assign cY       = rep && pY;
    assign cBrickX  = rep && pBX;
    assign cBrickY  = rep && pBY;
    assign ballLost = rep && pLost;

`ifdef COLLIDE_SCORE_EN
    logic [16:0] scoreSum;

    assign scoreSum = {1'b0, score} + 17'(3'd4 - {1'b0, rowq});

    always_ff @(posedge clock) begin
        if (reset || state == ST_MAIN_MENU) score <= '0;
        else if (brickClr) score <= scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
    end
`endif

endmodule

// File: tb/tb_collision_unit.sv
// Self-checking bench for collision_unit: job-level reference model,
// directed literal checks and randomized level1 traffic.
module tb_collision_unit;
    import bb_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] state = ST_MAIN_MENU;
    logic       check = 1'b0;
    logic [7:0] ballX = '0, ballY = '0, paddleX = '0;
    logic       cX, cY, cBrickX, cBrickY, ballLost, levelClear;
    logic [5:0] bricksLeft;
`ifdef COLLIDE_SCORE_EN
    logic [15:0] score;
`endif

    collision_unit dut (
        .clock      (clock),
        .reset      (reset),
        .state      (state),
        .check      (check),
        .ballX      (ballX),
        .ballY      (ballY),
        .paddleX    (paddleX),
        .cX         (cX),
        .cY         (cY),
        .cBrickX    (cBrickX),
        .cBrickY    (cBrickY),
        .ballLost   (ballLost),
        .levelClear (levelClear),
        .bricksLeft (bricksLeft)
`ifdef COLLIDE_SCORE_EN
        ,
        .score      (score)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit       mmap [BRICK_N];
    int       mleft = BRICK_N;
    int       mprev = -1;
    int       mscore = 0;
    bit       mlc = 1'b0;
    bit       jact = 1'b0;
    int       jage = 0;
    int       jx, jy, jpx;
    bit [4:0] jflags;

    // expectations for the current cycle
    bit [4:0] ef = '0;
    int       eleft = BRICK_N;
    bit       elc = 1'b0;
    int       escore = 0;
    bit       evalid = 1'b0;

    task automatic cmp(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s at %0t: actual %0d expected %0d", n, $time, a, e);
        end
    endtask

    task automatic reload();
        for (int i = 0; i < BRICK_N; i++) mmap[i] = 1'b1;
        mleft = BRICK_N;
    endtask

    task automatic resolve();
        int row, col, idx;
        bit fx, fy, fbx, fby, fl;
        fx  = (jx == 0) || (jx >= SCREEN_W - 1);
        fl  = (jy >= SCREEN_H - 1);
        fy  = (jy == 0) ||
              (jy == PADDLE_Y - 1 && jx >= jpx && jx <= jpx + PADDLE_W - 1);
        fbx = 1'b0;
        fby = 1'b0;
        if (jy >= BRICK_Y0 && jy < BRICK_Y0 + BRICK_ROWS * BRICK_H &&
            jx < SCREEN_W) begin
            row = (jy - BRICK_Y0) / BRICK_H;
            col = jx / BRICK_W;
            idx = row * BRICK_COLS + col;
            if (mmap[idx]) begin
                mmap[idx] = 1'b0;
                mleft--;
                mscore = mscore + (4 - row);
                if (mscore > 65535) mscore = 65535;
                if (mprev >= 0 && mprev / BRICK_COLS == row &&
                    mprev % BRICK_COLS != col) fbx = 1'b1;
                else fby = 1'b1;
            end
            mprev = idx;
        end else begin
            mprev = -1;
        end
        jflags = {fx, fy, fbx, fby, fl};
    endtask

    // one clock cycle: drive inputs, publish expected outputs, advance model
    task automatic cyc(input bit r, input logic [2:0] s, input bit c,
                       input int x, input int y, input int p);
        bit acc;
        @(posedge clock);
        #1;
        reset   = r;
        state   = s;
        check   = c;
        ballX   = 8'(x);
        ballY   = 8'(y);
        paddleX = 8'(p);
        ef     = (jact && jage == 4 && s == ST_LEVEL1) ? jflags : 5'b0;
        eleft  = mleft;
        elc    = mlc;
        escore = mscore;
        evalid = 1'b1;
        if (r) begin
            reload();
            jact   = 1'b0;
            mprev  = -1;
            mscore = 0;
            mlc    = 1'b0;
        end else begin
            acc = !jact && c && (s == ST_LEVEL1);
            if (s == ST_MAIN_MENU) begin
                reload();
                mscore = 0;
            end
            if (s != ST_LEVEL1) jact = 1'b0;
            else if (jact) begin
                if (jage == 3) resolve();
                if (jage == 4) jact = 1'b0;
                else jage++;
            end
            if (acc) begin
                jact = 1'b1;
                jage = 1;
                jx   = x;
                jy   = y;
                jpx  = p;
            end
            mlc = (s == ST_LEVEL1) && (mleft == 0);
        end
    endtask

    always @(negedge clock) begin
        if (evalid) begin
            cmp("cX", int'(cX), int'(ef[4]));
            cmp("cY", int'(cY), int'(ef[3]));
            cmp("cBrickX", int'(cBrickX), int'(ef[2]));
            cmp("cBrickY", int'(cBrickY), int'(ef[1]));
            cmp("ballLost", int'(ballLost), int'(ef[0]));
            cmp("levelClear", int'(levelClear), int'(elc));
            cmp("bricksLeft", int'(bricksLeft), eleft);
`ifdef COLLIDE_SCORE_EN
            cmp("score", int'(score), escore);
`endif
        end
    end

    // check at N, then idle through N+4 and capture outputs in the N+4 cycle
    task automatic do_check(input int x, input int y, input int p,
                            output bit [4:0] f, output int left, output bit lc);
        cyc(1'b0, ST_LEVEL1, 1'b1, x, y, p);
        for (int i = 0; i < 4; i++) cyc(1'b0, ST_LEVEL1, 1'b0, x, y, p);
        @(negedge clock);
        f    = {cX, cY, cBrickX, cBrickY, ballLost};
        left = int'(bricksLeft);
        lc   = levelClear;
    endtask

    task automatic rand_pos(output int x, output int y, output int p);
        int r;
        int xe [6];
        int ye [5];
        xe = '{0, 1, 158, 159, 160, 255};
        ye = '{0, 118, 119, 120, 108};
        r = int'($urandom_range(0, 99));
        x = (r < 20) ? xe[$urandom_range(0, 5)] : int'($urandom_range(0, 175));
        r = int'($urandom_range(0, 99));
        if (r < 40)      y = int'($urandom_range(14, 49));
        else if (r < 60) y = PADDLE_Y - 1;
        else if (r < 72) y = ye[$urandom_range(0, 4)];
        else             y = int'($urandom_range(0, 127));
        r = int'($urandom_range(0, 99));
        p = (r < 25) ? int'($urandom_range(140, 255))
                     : int'($urandom_range(0, 160));
        if (int'($urandom_range(0, 3)) == 0 && y == PADDLE_Y - 1)
            x = p + int'($urandom_range(0, 17)) - 1;
        if (x < 0) x = 0;
        if (x > 255) x = 255;
    endtask

    initial begin
        bit [4:0] f;
        int left;
        bit lc;
        int x, y, p, r, gap, extra, abortAt;

        for (int i = 0; i < BRICK_N; i++) mmap[i] = 1'b1;

        cyc(1'b1, ST_MAIN_MENU, 1'b0, 0, 0, 0);
        cyc(1'b0, ST_LEVEL1, 1'b0, 0, 0, 0);
        @(negedge clock);
        cmp("reset_bricksLeft", int'(bricksLeft), 40);
        cmp("reset_flags", int'({cX, cY, cBrickX, cBrickY, ballLost}), 0);

        do_check(0, 60, 0, f, left, lc);
        cmp("wall_flags", int'(f), int'(5'b10000));
        cmp("wall_left", left, 40);

        do_check(159, 109, 150, f, left, lc);
        cmp("paddle_edge_flags", int'(f), int'(5'b11000));
        do_check(5, 109, 150, f, left, lc);
        cmp("paddle_nowrap_flags", int'(f), int'(5'b00000));

        do_check(35, 20, 0, f, left, lc);
        cmp("brickY_flags", int'(f), int'(5'b00010));
        cmp("brickY_left", left, 39);
        do_check(35, 20, 0, f, left, lc);
        cmp("dead_cell_flags", int'(f), int'(5'b00000));
        cmp("dead_cell_left", left, 39);

        do_check(40, 40, 0, f, left, lc);
        cmp("brickX_first_flags", int'(f), int'(5'b00010));
        do_check(50, 40, 0, f, left, lc);
        cmp("brickX_second_flags", int'(f), int'(5'b00100));
        cmp("brickX_left", left, 37);

        do_check(80, 119, 0, f, left, lc);
        cmp("loss_flags", int'(f), int'(5'b00001));

        cyc(1'b0, ST_LEVEL1, 1'b1, 100, 20, 0);
        cyc(1'b0, ST_LEVEL1, 1'b0, 100, 20, 0);
        cyc(1'b1, ST_LEVEL1, 1'b0, 100, 20, 0);
        cyc(1'b0, ST_LEVEL1, 1'b0, 100, 20, 0);
        cyc(1'b0, ST_LEVEL1, 1'b0, 100, 20, 0);
        @(negedge clock);
        cmp("abort_flags", int'({cX, cY, cBrickX, cBrickY, ballLost}), 0);
        cmp("abort_left", int'(bricksLeft), 40);

        cyc(1'b0, ST_MAIN_MENU, 1'b0, 0, 0, 0);
        for (int row = 0; row < BRICK_ROWS; row++)
            for (int col = 0; col < BRICK_COLS; col++) begin
                do_check(col * 16 + 8, 16 + row * 8 + 4, 0, f, left, lc);
                if (row == 0 && col == 1)
                    cmp("clear_row_flags", int'(f), int'(5'b00100));
            end
        cmp("clear_levelClear", int'(lc), 1);
        cmp("clear_left", left, 0);
`ifdef COLLIDE_SCORE_EN
        cmp("clear_score", int'(score), 100);
`endif
        cyc(1'b0, ST_MAIN_MENU, 1'b0, 0, 0, 0);
        cyc(1'b0, ST_LEVEL1, 1'b0, 0, 0, 0);
        @(negedge clock);
        cmp("menu_left", int'(bricksLeft), 40);
        cmp("menu_levelClear", int'(levelClear), 0);

        for (int n = 0; n < 700; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                for (int i = 0; i <= int'($urandom_range(0, 2)); i++)
                    cyc(1'b0, ST_MAIN_MENU, 1'(i == 0), 20, 20, 0);
            end else if (r < 5) begin
                for (int i = 0; i <= int'($urandom_range(0, 3)); i++)
                    cyc(1'b0, ST_END_SCREEN, 1'b1, 20, 20, 0);
            end else if (r < 7) begin
                cyc(1'b1, ST_LEVEL1, 1'b0, 0, 0, 0);
            end else begin
                rand_pos(x, y, p);
                cyc(1'b0, ST_LEVEL1, 1'b1, x, y, p);
                gap     = int'($urandom_range(4, 7));
                extra   = (int'($urandom_range(0, 99)) < 15) ?
                          int'($urandom_range(1, 4)) : 0;
                abortAt = (int'($urandom_range(0, 99)) < 5) ?
                          int'($urandom_range(1, 4)) : 0;
                for (int i = 1; i <= gap; i++) begin
                    if (i == abortAt)
                        cyc(1'b0, ST_END_SCREEN, 1'b0, x, y, p);
                    else begin
                        rand_pos(x, y, p);
                        cyc(1'b0, ST_LEVEL1, 1'(i == extra), x, y, p);
                    end
                end
            end
        end

        @(posedge clock);
        #1;
        evalid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_unit.md
# collision_unit

Collision detector for the brick-breaker datapath: the producer of the bounce flags that the ball mover consumes. On each movement tick it samples the ball and paddle positions, checks walls, the paddle and a 4×10 brick map, and returns one-cycle bounce pulses. It also clears hit bricks, tracks bricks remaining and flags ball loss and level clear to the game FSM.

## Interface
- SCREEN_W, 160: playfield width in pixels; x range 0..159.
- SCREEN_H, 120: playfield height in pixels; y range 0..119.
- PADDLE_Y, 110: paddle top row.
- PADDLE_W, 16: paddle width in pixels.
- BRICK_Y0, 16: top row of the brick field.
- clock  in  1  system clock; the only clock domain.
- reset  in  1  synchronous, active-high reset.
- state  in  3  game state (mainMenu / level1 / endScreen encodings from bb_pkg).
- check  in  1  one-cycle strobe, same tick that advances the ball.
- ballX, ballY  in  8 each  ball position, sampled on check.
- paddleX  in  8  paddle left edge, sampled on check.
- cX, cY  out  1 each  wall/paddle bounce pulses.
- cBrickX, cBrickY  out  1 each  brick bounce pulses.
- ballLost  out  1  pulse: ball reached the bottom row.
- levelClear  out  1  level, high while bricksLeft == 0 in level1.
- bricksLeft  out  6  count of live bricks, 0..40.

## Operation
- FSM states and transitions:
  - IDLE: on check with state == level1, latch ballX, ballY and paddleX, then go to WALLS.
  - WALLS → LOOKUP → RESOLVE → REPORT → IDLE.
- WALLS:
  - x == 0 or x ≥ SCREEN_W-1 sets pending X.
  - y == 0 sets pending Y.
  - y ≥ SCREEN_H-1 sets pending lost; lost does not bounce.
- Paddle (LOOKUP):
  - Hit when y == PADDLE_Y-1 and paddleX ≤ x ≤ paddleX+PADDLE_W-1.
  - The bound is computed at 9 bits, so no wrap occurs when paddleX > 144.
  - A hit sets pending Y.
- Bricks (LOOKUP):
  - Field is rows y ∈ [16, 48). Cell row = (y-16)>>3 (0..3); col = x[7:4] (0..9).
  - Outside the field, or x ≥ 160, means no brick check.
- RESOLVE:
  - If the cell bit is set: clear it and decrement bricksLeft.
  - Set brick X if the previous-check cell has the same row and a different column; otherwise set brick Y.
  - Update the previous cell register on every check, including checks with no hit.
- REPORT: drive all pending flags high for exactly one cycle, then clear the pending registers.
- Simultaneous events: all applicable flags assert together in the same REPORT cycle, e.g. cX and cBrickY.
- Brick map reload:
  - The map reloads all ones and bricksLeft reloads 40 on reset, and on every cycle state == mainMenu.
  - In endScreen the map holds and the FSM is forced to IDLE.
- A check that arrives outside IDLE is dropped, not queued.
- A state change away from level1 mid-sequence aborts to IDLE with no REPORT pulse.

## Timing
- Latency: check at cycle N → flags high in cycle N+4 only. The ball mover applies them before the next tick; the tick period must be ≥ 5 cycles.
- The map clear and bricksLeft decrement take effect at the end of the RESOLVE cycle (N+3).
- levelClear is registered and goes high at N+4 when the last brick is cleared.
- Reset values:
  - FSM = IDLE.
  - cX, cY, cBrickX, cBrickY, ballLost = 0.
  - levelClear = 0; bricksLeft = 40; map = all ones.
  - Previous cell = invalid, so the first brick hit reports Y.
- Reset asserted mid-sequence: IDLE next cycle, no pulse, map fully reloaded.

## Configuration
- COLLIDE_SCORE_EN defined:
  - Adds output score[15:0], reset 0, cleared in mainMenu.
  - Score increments by row weight (row 0 = 4, row 3 = 1) in the RESOLVE cycle of each brick hit.
  - Score saturates at 0xFFFF.
- Undefined: no score port or logic. All other behaviour is identical.

## Structure
- Shared package bb_pkg holds:
  - The 3-bit game-state encodings.
  - SCREEN_W/H, PADDLE_Y/W, BRICK_Y0, brick geometry (16×8 px, 4 rows × 10 cols).
  - The collision FSM state enum.
- Sub-module brick_map holds the 40-bit store:
  - Ports: row/col read, clear strobe, reload strobe, hit bit, and a bricksLeft counter.
- The top level contains the FSM, wall and paddle compares, and the pending-flag registers.

## Test plan
- Wall hit: level1, check with ball (0,60) → cX pulse at N+4 only; cY, cBrick* = 0; bricksLeft stays 40.
- Paddle with overflow guard:
  - paddleX=150, ball (159,109) → cX and cY asserted in the same cycle.
  - paddleX=150, ball (5,109) → no cY.
- Brick Y, then dead cell:
  - Ball (35,20) → cBrickY; cell (0,2) cleared; bricksLeft=39.
  - Repeat the same position → no brick pulse.
- Brick X: check at (40,40) → cBrickY, cell (3,2) cleared. Then check at (50,40) → cBrickX, cell (3,3) cleared.
- Loss and abort:
  - Ball (80,119) → ballLost; no cY.
  - Check, then reset asserted at N+2 → no pulses; map back to 40.
- Level clear: clear all 40 bricks via checks → levelClear high at N+4 of the last hit. Enter mainMenu → bricksLeft = 40, levelClear = 0. With COLLIDE_SCORE_EN, score = 100 before the mainMenu entry.
